// File: rtl/lcd_frame_reader.sv
// lcd_frame_reader: pulls packed pixel pairs from the show-ahead SDRAM read
// FIFO, unpacks them to 8-bit RGB and drives an LTM-style panel with
// HSYNC/VSYNC/DE timing. Every pin output is registered one clock after the
// counter position that produced it, so pop-to-pin latency is one clock.
// Optional build macro: LCD_GRAY_EN (drive luma on all three colour outputs).
module lcd_frame_reader #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 29
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEnable,
  input  logic [15:0] iRd1_data,
  input  logic [15:0] iRd2_data,
  input  logic        iRd_empty,
  output logic        oRead,
  output logic [7:0]  oLCD_R,
  output logic [7:0]  oLCD_G,
  output logic [7:0]  oLCD_B,
  output logic        oHSYNC_n,
  output logic        oVSYNC_n,
  output logic        oDE,
  output logic [15:0] oX,
  output logic [15:0] oY,
  output logic        oFrame_start,
  output logic        oUnderflow
);

  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FRONT);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  logic        active;
  logic        pixel_ok;
  logic        hs_zone;
  logic        vs_zone;
  logic [7:0]  r_unp;
  logic [7:0]  g_unp;
  logic [7:0]  b_unp;
  logic [7:0]  r_pix;
  logic [7:0]  g_pix;
  logic [7:0]  b_pix;

  assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign pixel_ok = active && !iRd_empty;
  assign hs_zone  = (h_cnt >= HS_START) && (h_cnt < HS_END);
  // v_cnt only moves on the h wrap, so VSYNC edges land on h_cnt = 0 lines
  assign vs_zone  = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // Reset gates the pop directly: the counters sit at 0,0 (an active
  // position) while reset is held, and no word may be consumed then.
  assign oRead = pixel_ok && iEnable && !iRst;

  assign r_unp = iRd1_data[9:2];
  assign g_unp = {iRd1_data[14:10], iRd2_data[14:12]};
  assign b_unp = iRd2_data[9:2];

`ifdef LCD_GRAY_EN
  // Luma weights sum to 256, so a 16-bit sum cannot overflow
  logic [15:0] gray_sum;
  assign gray_sum = 16'd77  * {8'h00, r_unp}
                  + 16'd150 * {8'h00, g_unp}
                  + 16'd29  * {8'h00, b_unp};
  assign r_pix = gray_sum[15:8];
  assign g_pix = gray_sum[15:8];
  assign b_pix = gray_sum[15:8];
  logic unused_gray;
  assign unused_gray = ^gray_sum[7:0];
`else
  assign r_pix = r_unp;
  assign g_pix = g_unp;
  assign b_pix = b_unp;
`endif

  // Padding bits of the packed words carry nothing for this path
  logic unused_bits;
  assign unused_bits = ^{iRd1_data[15], iRd1_data[1:0],
                         iRd2_data[15], iRd2_data[11:10], iRd2_data[1:0]};

  // Raster position: h wraps every line, v steps on each h wrap
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!iEnable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
    end else begin
      h_cnt <= h_cnt + 16'd1;
    end
  end

  // Pin register stage: pixel, syncs and coordinates move together
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oLCD_R       <= '0;
      oLCD_G       <= '0;
      oLCD_B       <= '0;
      oHSYNC_n     <= 1'b1;
      oVSYNC_n     <= 1'b1;
      oDE          <= 1'b0;
      oX           <= '0;
      oY           <= '0;
      oFrame_start <= 1'b0;
      oUnderflow   <= 1'b0;
    end else if (!iEnable) begin
      oLCD_R       <= '0;
      oLCD_G       <= '0;
      oLCD_B       <= '0;
      oHSYNC_n     <= 1'b1;
      oVSYNC_n     <= 1'b1;
      oDE          <= 1'b0;
      oX           <= '0;
      oY           <= '0;
      oFrame_start <= 1'b0;
      oUnderflow   <= 1'b0;
    end else begin
      // A starved active pixel still asserts DE but shows black
      oLCD_R       <= pixel_ok ? r_pix : 8'd0;
      oLCD_G       <= pixel_ok ? g_pix : 8'd0;
      oLCD_B       <= pixel_ok ? b_pix : 8'd0;
      oHSYNC_n     <= !hs_zone;
      oVSYNC_n     <= !vs_zone;
      oDE          <= active;
      oX           <= active ? h_cnt : 16'd0;
      oY           <= active ? v_cnt : 16'd0;
      oFrame_start <= (h_cnt == 16'd0) && (v_cnt == 16'd0);
      oUnderflow   <= oUnderflow | (active && iRd_empty);
    end
  end

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Bench for lcd_frame_reader with a shrunken raster so several frames fit
// in a short run. The reference model derives the raster position from a
// plain cycle count (pos % H_TOTAL, pos / H_TOTAL) and the region rules.
module tb_lcd_frame_reader;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst, en, empty;
  logic [15:0] rd1, rd2;
  logic        rd;
  logic [7:0]  lcd_r, lcd_g, lcd_b;
  logic        hs_n, vs_n, de, fs, uf;
  logic [15:0] ox, oy;

  always #5 clk = ~clk;

  lcd_frame_reader #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .iClk(clk), .iRst(rst), .iEnable(en),
    .iRd1_data(rd1), .iRd2_data(rd2), .iRd_empty(empty),
    .oRead(rd), .oLCD_R(lcd_r), .oLCD_G(lcd_g), .oLCD_B(lcd_b),
    .oHSYNC_n(hs_n), .oVSYNC_n(vs_n), .oDE(de), .oX(ox), .oY(oy),
    .oFrame_start(fs), .oUnderflow(uf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // One clock's worth of inputs at a known raster position
  typedef struct {
    logic        idle;
    logic        e;
    int          h;
    int          v;
    logic        emp;
    logic [15:0] d1;
    logic [15:0] d2;
  } cyc_t;

  typedef struct {
    logic [15:0] d1;
    logic [15:0] d2;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } vec_t;

  cyc_t prev;
  int   mt;      // raster position (cycles since frame start) of next cycle
  logic m_uf;    // expected sticky underflow

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [23:0] pix(input logic [15:0] d1, input logic [15:0] d2);
    int r, g, b;
    r = int'(d1[9:2]);
    g = int'({d1[14:10], d2[14:12]});
    b = int'(d2[9:2]);
`ifdef LCD_GRAY_EN
    begin
      int y;
      y = (77 * r + 150 * g + 29 * b) / 256;
      return {y[7:0], y[7:0], y[7:0]};
    end
`else
    return {r[7:0], g[7:0], b[7:0]};
`endif
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".R"}, lcd_r, 0);
    chk({tag, ".G"}, lcd_g, 0);
    chk({tag, ".B"}, lcd_b, 0);
    chk({tag, ".HS"}, hs_n, 1);
    chk({tag, ".VS"}, vs_n, 1);
    chk({tag, ".DE"}, de, 0);
    chk({tag, ".X"}, ox, 0);
    chk({tag, ".Y"}, oy, 0);
    chk({tag, ".FS"}, fs, 0);
    chk({tag, ".UF"}, uf, 0);
  endtask

  // Registered outputs now on the pins come from the cycle recorded in prev
  task automatic check_outputs();
    logic        act, ok;
    logic [23:0] p;
    if (prev.idle || !prev.e) begin
      m_uf = 1'b0;
      check_idle("idle");
    end else begin
      act  = (prev.h < HA) && (prev.v < VA);
      ok   = act && !prev.emp;
      p    = ok ? pix(prev.d1, prev.d2) : 24'd0;
      m_uf = m_uf | (act && prev.emp);
      chk("R", lcd_r, p[23:16]);
      chk("G", lcd_g, p[15:8]);
      chk("B", lcd_b, p[7:0]);
      chk("DE", de, act);
      chk("HS", hs_n, !(prev.h >= HA + HF && prev.h < HA + HF + HS));
      chk("VS", vs_n, !(prev.v >= VA + VF && prev.v < VA + VF + VS));
      chk("X", ox, act ? prev.h : 0);
      chk("Y", oy, act ? prev.v : 0);
      chk("FS", fs, (prev.h == 0) && (prev.v == 0));
      chk("UF", uf, m_uf);
    end
  endtask

  // Check the combinational pop for the inputs now applied, then record them
  task automatic commit();
    int h, v;
    h = mt % HT;
    v = mt / HT;
    chk("oRead", rd, en && !rst && (h < HA) && (v < VA) && !empty);
    prev = '{idle: 1'b0, e: en, h: h, v: v, emp: empty, d1: rd1, d2: rd2};
    mt   = en ? (mt + 1) % FT : 0;
  endtask

  task automatic step(input logic e, input logic emp, input logic [15:0] d1, input logic [15:0] d2);
    @(negedge clk);
    en = e; empty = emp; rd1 = d1; rd2 = d2;
    #1;
    check_outputs();
    commit();
  endtask

  // Mid-cycle async reset pulse; outputs must go idle before any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle("rst_now");
    chk("rst_now.oRead", rd, 0);
    m_uf = 1'b0;
    mt   = 0;
    prev.idle = 1'b1;
    @(negedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    #1;
    commit();
  endtask

  vec_t tbl[6];
  int   de_cnt, hs_cnt, vs_cnt, pop_cnt, fs_cnt, run, max_run;

  initial begin
`ifdef LCD_GRAY_EN
    tbl[0] = '{16'h5694, 16'h30F0, 8'h9C, 8'h9C, 8'h9C};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[2] = '{16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{16'h7C00, 16'h0000, 8'h91, 8'h91, 8'h91};
    tbl[4] = '{16'h03FC, 16'h73FC, 8'h6D, 8'h6D, 8'h6D};
    tbl[5] = '{16'h8003, 16'h0C03, 8'h00, 8'h00, 8'h00};
`else
    tbl[0] = '{16'h5694, 16'h30F0, 8'hA5, 8'hAB, 8'h3C};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[2] = '{16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{16'h7C00, 16'h0000, 8'h00, 8'hF8, 8'h00};
    tbl[4] = '{16'h03FC, 16'h73FC, 8'hFF, 8'h07, 8'hFF};
    tbl[5] = '{16'h8003, 16'h0C03, 8'h00, 8'h00, 8'h00};
`endif

    rst = 1'b1; en = 1'b0; empty = 1'b1; rd1 = '0; rd2 = '0;
    prev = '{idle: 1'b1, e: 1'b0, h: 0, v: 0, emp: 1'b1, d1: '0, d2: '0};
    mt = 0; m_uf = 1'b0;
    #2;
    check_idle("por");
    chk("por.oRead", rd, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    commit();

    // Unpack vectors on the first pixels of a frame, one per clock
    step(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) step(1'b1, 1'b0, tbl[i].d1, tbl[i].d2);
      else       step(1'b1, 1'b0, 16'h1234, 16'h5678);
      if (i == 0) chk("vec.first_pop", rd, 1);
      if (i > 0) begin
        chk("vec.R", lcd_r, tbl[i-1].r);
        chk("vec.G", lcd_g, tbl[i-1].g);
        chk("vec.B", lcd_b, tbl[i-1].b);
        chk("vec.DE", de, 1);
        chk("vec.X", ox, i - 1);
        chk("vec.Y", oy, 0);
        chk("vec.FS", fs, (i == 1));
        $display("vector %0d: rd1=%h rd2=%h -> R=%h G=%h B=%h x=%0d", i - 1,
                 tbl[i-1].d1, tbl[i-1].d2, lcd_r, lcd_g, lcd_b, ox);
      end
    end

    // Full frame, FIFO never empty: region lengths and pop count
    en = 1'b1; empty = 1'b0;
    do_reset();
    pop_cnt = int'(rd);
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; run = 0; max_run = 0;
    for (int k = 1; k <= FT; k++) begin
      step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
      if (k < FT) pop_cnt += int'(rd);
      de_cnt += int'(de);
      hs_cnt += int'(!hs_n);
      vs_cnt += int'(!vs_n);
      fs_cnt += int'(fs);
      run = de ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    chk("frame.pops", pop_cnt, HA * VA);
    chk("frame.de", de_cnt, HA * VA);
    chk("frame.de_run", max_run, HA);
    chk("frame.hs_low", hs_cnt, HS * VT);
    chk("frame.vs_low", vs_cnt, VS * HT);
    chk("frame.fs", fs_cnt, 1);
    $display("frame: pops=%0d de=%0d hs_low=%0d vs_low=%0d run=%0d", pop_cnt, de_cnt, hs_cnt, vs_cnt, max_run);

    // Single starved pixel at h=5, v=0 -> black DE pixel and sticky flag
    do_reset();
    for (int k = 0; k < FT - 4; k++) begin
      int pos;
      pos = mt;
      step(1'b1, (pos == 5), 16'($urandom), 16'($urandom));
      if (pos == 5) chk("uf.no_pop", rd, 0);
      if (pos == 6) begin
        chk("uf.DE", de, 1);
        chk("uf.R", lcd_r, 0);
        chk("uf.X", ox, 5);
        chk("uf.flag", uf, 1);
      end
    end
    chk("uf.held", uf, 1);
    step(1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b0, 16'h0, 16'h0);
    chk("uf.cleared", uf, 0);
    $display("underflow: flag held to end of frame, cleared by enable drop");

    // Randomized traffic with a reset pulse in the middle of a frame
    for (int k = 0; k < 3 * FT; k++) begin
      if (k == FT + 2 * HT + 3) begin
        en = 1'b1;
        do_reset();
        step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
        chk("rst_mid.FS", fs, 1);
        chk("rst_mid.X", ox, 0);
        chk("rst_mid.Y", oy, 0);
        $display("mid-frame reset: restart at x=%0d y=%0d fs=%0d", ox, oy, fs);
      end
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 5) == 0),
           16'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
